// File: rtl/reconstructor_dividendo.sv
// Sequential dividend reconstructor: numerador = cociente*denominador + resto.
// Optional macro RECON_EARLY_EXIT_EN ends CALC once the remaining quotient is zero.
module reconstructor_dividendo #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] cociente,
    input  logic [SIZE-1:0] denominador,
    input  logic [SIZE-1:0] resto,
    output logic [SIZE-1:0] numerador,
    output logic            overflow,
    output logic            done,
    output logic            busy
);

    localparam int CW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   quo_q;
    logic [SIZE-1:0]   den_q;
    logic [2*SIZE-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [SIZE-1:0]   num_q;
    logic              ovf_q;
    logic              done_q;
    logic [2*SIZE-1:0] addend;
    logic              calc_last;

`ifdef RECON_EARLY_EXIT_EN
    // Last CALC cycle when no set quotient bits remain after this shift
    assign calc_last = (quo_q[SIZE-1:1] == '0);
`else
    // Last CALC cycle after a fixed SIZE iterations
    assign calc_last = (cnt_q == CW'(SIZE - 1));
`endif

    // Partial product: divisor aligned to the current quotient bit weight
    always_comb begin
        addend = {{SIZE{1'b0}}, den_q} << cnt_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (calc_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs from the current state
    always_comb begin
        busy = (state_q == CALC) || (state_q == DONE);
    end

    // Operand capture and shift-add iteration, LSB of quotient first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            den_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            quo_q <= cociente;
            den_q <= denominador;
            acc_q <= {{SIZE{1'b0}}, resto};
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            if (quo_q[0]) acc_q <= acc_q + addend;
            quo_q <= quo_q >> 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result registers: updated only in DONE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                num_q <= acc_q[SIZE-1:0];
                ovf_q <= |acc_q[2*SIZE-1:SIZE];
            end
        end
    end

    assign numerador = num_q;
    assign overflow  = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reconstructor_dividendo.sv
// Self-checking bench for reconstructor_dividendo (SIZE=32).
// Arithmetic model plus directed vectors with literal expectations.
module tb_reconstructor_dividendo;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [SIZE-1:0] cociente;
    logic [SIZE-1:0] denominador;
    logic [SIZE-1:0] resto;
    logic [SIZE-1:0] numerador;
    logic            overflow;
    logic            done;
    logic            busy;

    int n_pass = 0;
    int n_total = 0;

    reconstructor_dividendo #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cociente    (cociente),
        .denominador (denominador),
        .resto       (resto),
        .numerador   (numerador),
        .overflow    (overflow),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Clocks from accepting start to the done cycle
    function automatic int lat_of(input logic [SIZE-1:0] c);
`ifdef RECON_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < SIZE; i++) if (c[i]) n = i + 1;
        return n + 1;
`else
        return SIZE + 1;
`endif
    endfunction

    // Transaction-level model: full 64-bit result, countdown to done
    int          m_rem = 0;
    logic [63:0] m_res = '0;
    logic [31:0] e_num = '0;
    logic        e_ovf = 1'b0;
    logic        e_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            e_num  = '0;
            e_ovf  = 1'b0;
            e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_res = {32'b0, cociente} * {32'b0, denominador}
                          + {32'b0, resto};
                    m_rem = lat_of(cociente);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    e_done = 1'b1;
                    e_num  = m_res[31:0];
                    e_ovf  = |m_res[63:32];
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            check("model_num", 64'(numerador), 64'(e_num));
            check("model_ovf", 64'(overflow), 64'(e_ovf));
            check("model_done", 64'(done), 64'(e_done));
            check("model_busy", 64'(busy), 64'(m_rem != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [31:0] c, input logic [31:0] d,
                          input logic [31:0] r, input logic [31:0] xn,
                          input logic xo, input int xlat);
        int lat;
        cociente    = c;
        denominador = d;
        resto       = r;
        start       = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        check("op_latency", 64'(lat), 64'(xlat));
        check("op_num", 64'(numerador), 64'(xn));
        check("op_ovf", 64'(overflow), 64'(xo));
    endtask

    initial begin
        int ndone;
        logic [31:0] c, d, r;
        logic [63:0] full;
        rst_n       = 1'b0;
        start       = 1'b0;
        cociente    = '0;
        denominador = '0;
        resto       = '0;
        repeat (3) tick();
        check("rst_num", 64'(numerador), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

`ifdef RECON_EARLY_EXIT_EN
        run_op(32'd7, 32'd5, 32'd3, 32'd38, 1'b0, 4);
        run_op(32'd0, 32'hFFFF_FFFF, 32'd9, 32'd9, 1'b0, 2);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b1, 18);
        run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b1, 33);
`else
        run_op(32'd7, 32'd5, 32'd3, 32'd38, 1'b0, 33);
        run_op(32'd0, 32'hFFFF_FFFF, 32'd9, 32'd9, 1'b0, 33);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b1, 33);
        run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b1, 33);
`endif
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 1'b1, 33);

        for (int i = 0; i < 4; i++) begin
            c = $urandom;
            d = $urandom;
            r = $urandom;
            full = {32'b0, c} * {32'b0, d} + {32'b0, r};
            run_op(c, d, r, full[31:0], |full[63:32], lat_of(c));
        end

        // start held high with operands changing every cycle
        ndone = 0;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cociente    = $urandom | 32'h8000_0000;
            denominador = $urandom;
            resto       = $urandom;
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) ndone++;
        end
        check("b2b_done_count", 64'(ndone), 64'd2);

        // Reset in the middle of CALC
        cociente    = 32'hFFFF_FFFF;
        denominador = 32'd5;
        resto       = 32'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_num", 64'(numerador), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_hold_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_done", 64'(done), 64'd0);
`ifdef RECON_EARLY_EXIT_EN
        run_op(32'd7, 32'd5, 32'd3, 32'd38, 1'b0, 4);
`else
        run_op(32'd7, 32'd5, 32'd3, 32'd38, 1'b0, 33);
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
